// File: rtl/paint_pkg.sv
// Shared definitions for the paint canvas: colour codes, the RGB pixel
// type, the fixed palette and the cursor outline colour.
package paint_pkg;

    typedef logic [2:0] color_t;

    localparam color_t C_WHITE   = 3'd0;
    localparam color_t C_BLACK   = 3'd1;
    localparam color_t C_RED     = 3'd2;
    localparam color_t C_GREEN   = 3'd3;
    localparam color_t C_BLUE    = 3'd4;
    localparam color_t C_YELLOW  = 3'd5;
    localparam color_t C_CYAN    = 3'd6;
    localparam color_t C_MAGENTA = 3'd7;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Canvas cells per axis
    localparam int GRID = 8;

    // Mid-grey outline so the cursor stays visible on every palette colour
    localparam rgb_t CURSOR_RGB = rgb_t'(12'h888);

    function automatic rgb_t palette(input color_t code);
        case (code)
            C_WHITE:   palette = rgb_t'(12'hFFF);
            C_BLACK:   palette = rgb_t'(12'h000);
            C_RED:     palette = rgb_t'(12'hF00);
            C_GREEN:   palette = rgb_t'(12'h0F0);
            C_BLUE:    palette = rgb_t'(12'h00F);
            C_YELLOW:  palette = rgb_t'(12'hFF0);
            C_CYAN:    palette = rgb_t'(12'h0FF);
            default:   palette = rgb_t'(12'hF0F);
        endcase
    endfunction

endpackage

// File: rtl/pixel_scanout_vga_timing.sv
// vga_timing: free-running horizontal/vertical position counters and the
// raw (unpipelined) timing flags derived from them.
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   hcount, vcount        current position (registered)
//   active                position is inside the visible area
//   hsync_raw, vsync_raw  active-low syncs for the current position
//   frame_start_raw       high at position (0,0)
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       active,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       frame_start_raw
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [9:0] hcount_reg;
    logic [9:0] vcount_reg;
    logic       h_last;
    logic       v_last;

    assign h_last = (hcount_reg == 10'(H_TOTAL - 1));
    assign v_last = (vcount_reg == 10'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else if (h_last) begin
            hcount_reg <= '0;
            vcount_reg <= v_last ? 10'd0 : vcount_reg + 10'd1;
        end else begin
            hcount_reg <= hcount_reg + 10'd1;
        end
    end

    assign hcount          = hcount_reg;
    assign vcount          = vcount_reg;
    assign active          = (hcount_reg < 10'(H_ACTIVE)) && (vcount_reg < 10'(V_ACTIVE));
    assign hsync_raw       = !((hcount_reg >= 10'(HS_START)) && (hcount_reg <= 10'(HS_END)));
    assign vsync_raw       = !((vcount_reg >= 10'(VS_START)) && (vcount_reg <= 10'(VS_END)));
    assign frame_start_raw = (hcount_reg == 10'd0) && (vcount_reg == 10'd0);

endmodule

// File: rtl/pixel_scanout.sv
// pixel_scanout: reads the 8x8 canvas store in raster order and drives VGA.
// Stage 0 is the position counters plus the registered store address,
// stage 1 is the store's registered colour with delayed timing flags,
// stage 2 is the output register with palette / cursor / blanking applied.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   colorCode           cell colour from the store, one cycle after rx/ry
//   cx, cy, cursor_en   cursor cell and outline enable
//   rx, ry              store read address (cell index), 0 in blanking
//   hsync, vsync        active-low syncs
//   r, g, b             pixel colour, 0 in blanking
//   frame_start         one-cycle pulse with the first pixel of a frame
module pixel_scanout
    import paint_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int GRID     = paint_pkg::GRID
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] colorCode,
    input  logic [2:0] cx,
    input  logic [2:0] cy,
    input  logic       cursor_en,
    output logic [9:0] rx,
    output logic [9:0] ry,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CELL_W  = H_ACTIVE / GRID;
    localparam int CELL_H  = V_ACTIVE / GRID;

    logic [9:0] hcount, vcount;
    logic       active, hsync_raw, vsync_raw, frame_start_raw;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk             (clk),
        .reset           (reset),
        .hcount          (hcount),
        .vcount          (vcount),
        .active          (active),
        .hsync_raw       (hsync_raw),
        .vsync_raw       (vsync_raw),
        .frame_start_raw (frame_start_raw)
    );

    // ---------------- stage 0: cell tracking and read address ----------------
    logic [9:0] hsub_reg, hcell_reg, vsub_reg, vcell_reg;
    logic [9:0] hsub_next, hcell_next, vsub_next, vcell_next;
    logic [9:0] rx_reg, ry_reg;
    logic       h_wrap, v_wrap, hsub_wrap, vsub_wrap, cell_active_next, border0;

    assign h_wrap    = (hcount == 10'(H_TOTAL - 1));
    assign v_wrap    = (vcount == 10'(V_TOTAL - 1));
    assign hsub_wrap = (hsub_reg == 10'(CELL_W - 1));
    assign vsub_wrap = (vsub_reg == 10'(CELL_H - 1));

    always_comb begin
        hsub_next  = hsub_reg + 10'd1;
        hcell_next = hcell_reg;
        vsub_next  = vsub_reg;
        vcell_next = vcell_reg;
        if (h_wrap) begin
            hsub_next  = '0;
            hcell_next = '0;
        end else if (hsub_wrap) begin
            hsub_next  = '0;
            hcell_next = hcell_reg + 10'd1;
        end
        if (h_wrap) begin
            if (v_wrap) begin
                vsub_next  = '0;
                vcell_next = '0;
            end else if (vsub_wrap) begin
                vsub_next  = '0;
                vcell_next = vcell_reg + 10'd1;
            end else begin
                vsub_next  = vsub_reg + 10'd1;
            end
        end
        // The visible area is exactly GRID cells on each axis, so the next
        // position is visible iff both next cell indices are below GRID.
        cell_active_next = (hcell_next < 10'(GRID)) && (vcell_next < 10'(GRID));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsub_reg  <= '0;
            hcell_reg <= '0;
            vsub_reg  <= '0;
            vcell_reg <= '0;
            rx_reg    <= '0;
            ry_reg    <= '0;
        end else begin
            hsub_reg  <= hsub_next;
            hcell_reg <= hcell_next;
            vsub_reg  <= vsub_next;
            vcell_reg <= vcell_next;
            // Address is registered alongside the counters it belongs to
            rx_reg    <= cell_active_next ? hcell_next : 10'd0;
            ry_reg    <= cell_active_next ? vcell_next : 10'd0;
        end
    end

    assign border0 = cursor_en
                  && (hcell_reg == {7'd0, cx}) && (vcell_reg == {7'd0, cy})
                  && ((hsub_reg == 10'd0) || hsub_wrap || (vsub_reg == 10'd0) || vsub_wrap);

    // ---------------- stage 1: flags travelling with colorCode ----------------
    logic act1_reg, hs1_reg, vs1_reg, fs1_reg, border1_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            act1_reg    <= 1'b0;
            hs1_reg     <= 1'b1;
            vs1_reg     <= 1'b1;
            fs1_reg     <= 1'b0;
            border1_reg <= 1'b0;
        end else begin
            act1_reg    <= active;
            hs1_reg     <= hsync_raw;
            vs1_reg     <= vsync_raw;
            fs1_reg     <= frame_start_raw;
            border1_reg <= border0;
        end
    end

    // ---------------- stage 2: output registers ----------------
    rgb_t rgb_reg;
    logic hsync_reg, vsync_reg, fs_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg   <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            fs_reg    <= 1'b0;
        end else begin
            hsync_reg <= hs1_reg;
            vsync_reg <= vs1_reg;
            fs_reg    <= fs1_reg;
            if (!act1_reg)
                rgb_reg <= '0;
            else if (border1_reg)
                rgb_reg <= CURSOR_RGB;
            else
                rgb_reg <= palette(color_t'(colorCode));
        end
    end

    assign rx          = rx_reg;
    assign ry          = ry_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign frame_start = fs_reg;
    assign r           = rgb_reg.r;
    assign g           = rgb_reg.g;
    assign b           = rgb_reg.b;

endmodule

// File: tb/tb_pixel_scanout.sv
// Bench for pixel_scanout using a reduced raster (80x55 total, 64x48 active,
// 8x6 cells) so that whole frames fit in a short run.
module tb_pixel_scanout;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 80
    localparam int VT = VA + VF + VS + VB;   // 55
    localparam int FR = HT * VT;             // 4400
    localparam int CW = 8, CH = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] colorCode = 3'd0;
    logic [2:0] cx = 3'd0, cy = 3'd0;
    logic       cursor_en = 1'b0;
    logic [9:0] rx, ry;
    logic       hsync, vsync, frame_start;
    logic [3:0] r, g, b;

    pixel_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .GRID(8)
    ) dut (
        .clk(clk), .reset(reset), .colorCode(colorCode),
        .cx(cx), .cy(cy), .cursor_en(cursor_en),
        .rx(rx), .ry(ry), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Store model: registered read, either rx+ry or a constant code
    bit         use_const = 1'b0;
    logic [2:0] const_code = 3'd0;
    always @(posedge clk)
        colorCode <= use_const ? const_code : (rx[2:0] + ry[2:0]);

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [11:0] pal(input int c);
        case (c)
            0: pal = 12'hFFF;
            1: pal = 12'h000;
            2: pal = 12'hF00;
            3: pal = 12'h0F0;
            4: pal = 12'h00F;
            5: pal = 12'hFF0;
            6: pal = 12'h0FF;
            default: pal = 12'hF0F;
        endcase
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx"}, 32'(rx), 0);
        chk({tag, "_ry"}, 32'(ry), 0);
        chk({tag, "_hsync"}, 32'(hsync), 1);
        chk({tag, "_vsync"}, 32'(vsync), 1);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_rgb"}, 32'({r, g, b}), 0);
    endtask

    // Reference raster model: address follows position cyc, pins follow cyc-2
    task automatic model_check();
        int p, h, v, erx, ery, code;
        bit ehs, evs, efs, brd;
        logic [11:0] ergb;
        h = cyc % HT;
        v = (cyc / HT) % VT;
        erx = (h < HA && v < VA) ? h / CW : 0;
        ery = (h < HA && v < VA) ? v / CH : 0;
        ehs = 1; evs = 1; efs = 0; ergb = 12'h000;
        p = cyc - 2;
        if (p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            ehs = !(h >= HA + HF && h < HA + HF + HS);
            evs = !(v >= VA + VF && v < VA + VF + VS);
            efs = (h == 0 && v == 0);
            if (h < HA && v < VA) begin
                code = use_const ? int'(const_code) : ((h / CW + v / CH) % 8);
                brd = cursor_en && (h / CW == int'(cx)) && (v / CH == int'(cy))
                      && (h % CW == 0 || h % CW == CW - 1 || v % CH == 0 || v % CH == CH - 1);
                ergb = brd ? 12'h888 : pal(code);
            end
        end
        chk("m_rx", 32'(rx), 32'(erx));
        chk("m_ry", 32'(ry), 32'(ery));
        chk("m_hsync", 32'(hsync), 32'(ehs));
        chk("m_vsync", 32'(vsync), 32'(evs));
        chk("m_fs", 32'(frame_start), 32'(efs));
        chk("m_rgb", 32'({r, g, b}), 32'(ergb));
    endtask

    typedef struct {
        int          t;
        int          rx;
        int          ry;
        bit          hs;
        bit          vs;
        bit          fs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals("rst");
        end
        reset = 1'b0;
        cyc = 0;
        cursor_en = 1'b1;
        cx = 3'd2;
        cy = 3'd3;

        //            t     rx ry hs vs fs rgb
        tbl.push_back('{0,    0, 0, 1, 1, 0, 12'h000});
        tbl.push_back('{1,    0, 0, 1, 1, 0, 12'h000});
        tbl.push_back('{2,    0, 0, 1, 1, 1, 12'hFFF});  // first pixel (0,0)
        tbl.push_back('{3,    0, 0, 1, 1, 0, 12'hFFF});
        tbl.push_back('{8,    1, 0, 1, 1, 0, 12'hFFF});  // rx steps at h=8
        tbl.push_back('{10,   1, 0, 1, 1, 0, 12'h000});  // cell 1: black
        tbl.push_back('{64,   0, 0, 1, 1, 0, 12'hF0F});  // rx blank, last pixel cell 7
        tbl.push_back('{66,   0, 0, 1, 1, 0, 12'h000});  // blanking
        tbl.push_back('{69,   0, 0, 1, 1, 0, 12'h000});
        tbl.push_back('{70,   0, 0, 0, 1, 0, 12'h000});  // hsync starts (h=68)
        tbl.push_back('{77,   0, 0, 0, 1, 0, 12'h000});  // hsync last (h=75)
        tbl.push_back('{78,   0, 0, 1, 1, 0, 12'h000});
        tbl.push_back('{490,  1, 1, 1, 1, 0, 12'hF00});  // line 6 h=8: code 2
        tbl.push_back('{1462, 2, 3, 1, 1, 0, 12'h888});  // cursor top edge
        tbl.push_back('{1618, 2, 3, 1, 1, 0, 12'h888});  // cursor left edge
        tbl.push_back('{1622, 2, 3, 1, 1, 0, 12'hFF0});  // cursor interior, code 5
        tbl.push_back('{1625, 3, 3, 1, 1, 0, 12'h888});  // cursor right edge
        tbl.push_back('{1860, 2, 3, 1, 1, 0, 12'h888});  // cursor bottom edge
        tbl.push_back('{1938, 2, 4, 1, 1, 0, 12'h0FF});  // below cursor, code 6
        tbl.push_back('{4001, 0, 0, 1, 1, 0, 12'h000});
        tbl.push_back('{4002, 0, 0, 1, 0, 0, 12'h000});  // vsync starts (line 50)
        tbl.push_back('{4161, 0, 0, 1, 0, 0, 12'h000});  // vsync last (line 51)
        tbl.push_back('{4162, 0, 0, 1, 1, 0, 12'h000});
        tbl.push_back('{4401, 0, 0, 1, 1, 0, 12'h000});
        tbl.push_back('{4402, 0, 0, 1, 1, 1, 12'hFFF});  // next frame start

        for (int i = 0; i < tbl.size(); i++) begin
            while (cyc < tbl[i].t) step();
            chk("v_rx", 32'(rx), 32'(tbl[i].rx));
            chk("v_ry", 32'(ry), 32'(tbl[i].ry));
            chk("v_hsync", 32'(hsync), 32'(tbl[i].hs));
            chk("v_vsync", 32'(vsync), 32'(tbl[i].vs));
            chk("v_fs", 32'(frame_start), 32'(tbl[i].fs));
            chk("v_rgb", 32'({r, g, b}), 32'(tbl[i].rgb));
            $display("vec %0d t=%0d rx=%0d ry=%0d hs=%b vs=%b fs=%b rgb=%h",
                     i, cyc, rx, ry, hsync, vsync, frame_start, {r, g, b});
        end

        // Palette sweep: one constant code per frame, switched in vblank
        for (int k = 0; k < 8; k++) begin
            while ((cyc - 2) % FR != FR - 100) step();
            cursor_en  = 1'b0;
            use_const  = 1'b1;
            const_code = 3'(k);
            repeat (FR) begin
                step();
                model_check();
            end
            $display("palette frame code=%0d compared=%0d mismatched=%0d", k, n_cmp, n_bad);
        end

        // Reset in the middle of line 30, then check a full fresh frame
        while ((cyc - 2) % FR != FR - 100) step();
        use_const = 1'b0;
        cursor_en = 1'b1;
        cx = 3'd5;
        cy = 3'd1;
        while (cyc % FR != 30 * HT + 10) step();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals("midrst");
        end
        reset = 1'b0;
        cyc = 0;
        model_check();
        repeat (FR + 2) begin
            step();
            model_check();
        end
        $display("mid-frame reset frame compared=%0d mismatched=%0d", n_cmp, n_bad);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
